// File: rtl/reg_burst_bank.sv
// Byte-framed register bank: CMD/LEN header, then auto-incrementing burst write or read of NUM_REGS 8-bit registers.
// Latency: write lands 1 clk after its data byte; first read start 1 clk after LEN, next start 1 clk after tx_done_in.
// Backpressure: none on rx (bytes arriving during a read are dropped); tx paced by the tx_start_out/tx_done_in handshake.
//
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   rx_data_in, rx_valid_in        received byte + one-cycle valid pulse
//   tx_data_out, tx_start_out      byte to send (held until tx_done_in) + one-cycle start pulse
//   tx_done_in                     one-cycle pulse when the transmitter finishes
//   status_in                      live status, readable at address 1
//   regs_out                       flat register image, register k at [8k+7:8k]
//   wr_strobe_out, wr_addr_out     one-cycle pulse and address per register actually written
//   timeout_out                    one-cycle pulse when a frame is abandoned for inter-byte timeout

module reg_burst_bank #(
    parameter int                      NUM_REGS     = 16,
    parameter logic [NUM_REGS*8-1:0]   RESET_VALUES = '0,
    parameter logic [7:0]              ID_VALUE     = 8'hBA,
    parameter int                      TIMEOUT_CLKS = 4096
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [7:0]              rx_data_in,
    input  logic                    rx_valid_in,
    output logic [7:0]              tx_data_out,
    output logic                    tx_start_out,
    input  logic                    tx_done_in,
    input  logic [7:0]              status_in,
    output logic [NUM_REGS*8-1:0]   regs_out,
    output logic                    wr_strobe_out,
    output logic [6:0]              wr_addr_out,
    output logic                    timeout_out
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    // The "send" action is taken on the transition into the wait state
    // (from LEN, or from RWAIT on tx_done_in) so the registered start pulse
    // appears one cycle after its trigger; no separate send state is needed.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_WDATA,
        ST_RWAIT
    } state_t;

    state_t        state_q, state_d;
    logic          rd_q, rd_d;
    logic [6:0]    addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;          // beats remaining after the current one
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    regs_q [2:NUM_REGS-1];
    logic [7:0]    regs_d [2:NUM_REGS-1];
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [6:0]    wr_addr_q, wr_addr_d;
    logic          timeout_q, timeout_d;

    logic [6:0]    rd_addr;
    logic [7:0]    rd_byte;

    // Read source: the start address when leaving LEN, the next address when
    // a beat completes in RWAIT. Out-of-range addresses read as zero.
    always_comb begin
        rd_addr = (state_q == ST_RWAIT) ? addr_q + 7'd1 : addr_q;
        rd_byte = 8'h00;
        if (rd_addr == 7'd0) begin
            rd_byte = ID_VALUE;
        end else if (rd_addr == 7'd1) begin
            rd_byte = status_in;
        end
        for (int k = 2; k < NUM_REGS; k++) begin
            if (rd_addr == 7'(k)) begin
                rd_byte = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        regs_d      = regs_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_in) begin
                    rd_d    = rx_data_in[7];
                    addr_d  = rx_data_in[6:0];
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (rx_valid_in) begin
                    cnt_d = rx_data_in;
                    if (rd_q) begin
                        tx_data_d  = rd_byte;
                        tx_start_d = 1'b1;
                        state_d    = ST_RWAIT;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_WDATA: begin
                if (rx_valid_in) begin
                    // Only addresses 2..NUM_REGS-1 are writable; others are
                    // consumed silently so the burst still advances.
                    for (int k = 2; k < NUM_REGS; k++) begin
                        if (addr_q == 7'(k)) begin
                            regs_d[k]   = rx_data_in;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                        end
                    end
                    addr_d = addr_q + 7'd1;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_RWAIT: begin
                if (tx_done_in) begin
                    addr_d = addr_q + 7'd1;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d      = cnt_q - 8'd1;
                        tx_data_d  = rd_byte;
                        tx_start_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            addr_q      <= 7'd0;
            cnt_q       <= 8'd0;
            tmo_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            timeout_q   <= 1'b0;
            for (int k = 2; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VALUES[8*k +: 8];
            end
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            timeout_q   <= timeout_d;
            regs_q      <= regs_d;
        end
    end

    // Slices 0 and 1 are pure mirrors of the ID constant and live status.
    assign regs_out[7:0]  = ID_VALUE;
    assign regs_out[15:8] = status_in;
    for (genvar k = 2; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[8*k +: 8] = regs_q[k];
    end

    assign tx_data_out   = tx_data_q;
    assign tx_start_out  = tx_start_q;
    assign wr_strobe_out = wr_strobe_q;
    assign wr_addr_out   = wr_addr_q;
    assign timeout_out   = timeout_q;

endmodule
